// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, framebuffer geometry and the RRRGGGBB pixel expansion
// shared by the scan-out path and the framebuffer writer.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int H_TOTAL   = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL   = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int FB_PIXELS = VGA_H_ACTIVE * VGA_V_ACTIVE;

    localparam int FB_ADDR_W = 19;
    localparam int CNT_W     = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicate the short fields so full-scale codes map to 8'hFF and zero stays zero.
    function automatic rgb888_t rgb332_expand(input logic [7:0] d);
        rgb888_t c;
        c.r = {d[7:5], d[7:5], d[7:6]};
        c.g = {d[4:2], d[4:2], d[4:3]};
        c.b = {d[1:0], d[1:0], d[1:0], d[1:0]};
        return c;
    endfunction

endpackage

// File: rtl/vga_framebuffer_scanout_timing.sv
// Raster counters, undelayed sync/blank strobes and the incremental linear read address.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic                 vga_clock,
    input  logic                 reset_n,
    output logic                 de_raw,
    output logic                 hs_raw,
    output logic                 vs_raw,
    output logic                 first_raw,
    output logic [FB_ADDR_W-1:0] read_address
);

    localparam int GEN_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int GEN_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_STOP   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(GEN_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_STOP   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(GEN_V_TOTAL - 1);

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             line_end;
    logic             frame_end;

    assign line_end  = (h_count == H_LAST);
    assign frame_end = line_end && (v_count == V_LAST);

    assign de_raw    = (h_count < H_ACT_END) && (v_count < V_ACT_END);
    assign hs_raw    = !((h_count >= HS_START) && (h_count < HS_STOP));
    assign vs_raw    = !((v_count >= VS_START) && (v_count < VS_STOP));
    assign first_raw = (h_count == '0) && (v_count == '0);

    // The address only moves on visible pixels, so it tops out at the pixel count
    // after the last visible pixel and rewinds just before (0,0).
    always_ff @(posedge vga_clock) begin
        if (!reset_n) begin
            h_count      <= '0;
            v_count      <= '0;
            read_address <= '0;
        end else begin
            if (line_end) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
            end else begin
                h_count <= h_count + CNT_W'(1);
            end

            if (frame_end) begin
                read_address <= '0;
            end else if (de_raw) begin
                read_address <= read_address + FB_ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_framebuffer_scanout.sv
// Framebuffer read side: issues pixel addresses, realigns sync/blank with the returned
// bytes and drives registered 24-bit RGB plus HS/VS/DE to the transmitter.
module vga_framebuffer_scanout
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_FP         = VGA_H_FP,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BP         = VGA_H_BP,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_FP         = VGA_V_FP,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BP         = VGA_V_BP,
    parameter int READ_LATENCY = 1
) (
    input  logic                 vga_clock,
    input  logic                 reset_n,
    output logic                 read_clock,
    output logic [FB_ADDR_W-1:0] read_address,
    input  logic [7:0]           read_data,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_de,
    output logic                 frame_start
);

    logic de_raw;
    logic hs_raw;
    logic vs_raw;
    logic first_raw;

    assign read_clock = vga_clock;

    vga_timing_generator #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .vga_clock    (vga_clock),
        .reset_n      (reset_n),
        .de_raw       (de_raw),
        .hs_raw       (hs_raw),
        .vs_raw       (vs_raw),
        .first_raw    (first_raw),
        .read_address (read_address)
    );

    // Stage p0: control delayed by the RAM latency so its last tap lines up with read_data
    logic [READ_LATENCY-1:0] vld_p0;
    logic [READ_LATENCY-1:0] hs_p0;
    logic [READ_LATENCY-1:0] vs_p0;
    logic [READ_LATENCY-1:0] first_p0;
    rgb888_t                 pix_p0;

    always_ff @(posedge vga_clock) begin
        if (!reset_n) begin
            vld_p0   <= '0;
            hs_p0    <= '1;
            vs_p0    <= '1;
            first_p0 <= '0;
        end else begin
            vld_p0[0]   <= de_raw;
            hs_p0[0]    <= hs_raw;
            vs_p0[0]    <= vs_raw;
            first_p0[0] <= first_raw;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p0[i]   <= vld_p0[i-1];
                hs_p0[i]    <= hs_p0[i-1];
                vs_p0[i]    <= vs_p0[i-1];
                first_p0[i] <= first_p0[i-1];
            end
        end
    end

    always_comb begin
        pix_p0 = '0;
        if (vld_p0[READ_LATENCY-1]) begin
            pix_p0 = rgb332_expand(read_data);
        end
    end

    // Stage p1: output registers; blanking forces black so stale RAM data never leaks
    always_ff @(posedge vga_clock) begin
        if (!reset_n) begin
            vga_de      <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            vga_de                <= vld_p0[READ_LATENCY-1];
            vga_hs                <= hs_p0[READ_LATENCY-1];
            vga_vs                <= vs_p0[READ_LATENCY-1];
            frame_start           <= first_p0[READ_LATENCY-1];
            {vga_r, vga_g, vga_b} <= pix_p0;
        end
    end

endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// Scoreboard bench: one full-size scan-out and two reduced-raster copies (latency 1 and 3).
module tb_vga_framebuffer_scanout;

    localparam int NI = 3;
    localparam int S_HA = 32, S_HFP = 2, S_HS = 4, S_HBP = 3;
    localparam int S_VA = 12, S_VFP = 1, S_VS = 2, S_VBP = 2;
    localparam int S_FRAME = (S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP);

    localparam int P_HA  [NI] = '{640, S_HA,  S_HA};
    localparam int P_HFP [NI] = '{16,  S_HFP, S_HFP};
    localparam int P_HS  [NI] = '{96,  S_HS,  S_HS};
    localparam int P_HBP [NI] = '{48,  S_HBP, S_HBP};
    localparam int P_VA  [NI] = '{480, S_VA,  S_VA};
    localparam int P_VFP [NI] = '{10,  S_VFP, S_VFP};
    localparam int P_VS  [NI] = '{2,   S_VS,  S_VS};
    localparam int P_VBP [NI] = '{33,  S_VBP, S_VBP};
    localparam int P_LAT [NI] = '{1,   1,     3};

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] rgb;
    } out_t;

    localparam out_t BLANK = {1'b0, 1'b1, 1'b1, 1'b0, 24'h0};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rclk [NI];
    logic [18:0] addr [NI];
    logic [7:0]  rd   [NI];
    logic [7:0]  vr   [NI];
    logic [7:0]  vg   [NI];
    logic [7:0]  vb   [NI];
    logic        hs   [NI];
    logic        vs   [NI];
    logic        de   [NI];
    logic        fs   [NI];

    always #20 clk = ~clk;

    vga_framebuffer_scanout #(.READ_LATENCY(1)) dut_full (
        .vga_clock(clk), .reset_n(reset_n), .read_clock(rclk[0]), .read_address(addr[0]),
        .read_data(rd[0]), .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]),
        .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_de(de[0]), .frame_start(fs[0]));

    vga_framebuffer_scanout #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .READ_LATENCY(1)
    ) dut_s1 (
        .vga_clock(clk), .reset_n(reset_n), .read_clock(rclk[1]), .read_address(addr[1]),
        .read_data(rd[1]), .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(vb[1]),
        .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_de(de[1]), .frame_start(fs[1]));

    vga_framebuffer_scanout #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .READ_LATENCY(3)
    ) dut_s3 (
        .vga_clock(clk), .reset_n(reset_n), .read_clock(rclk[2]), .read_address(addr[2]),
        .read_data(rd[2]), .vga_r(vr[2]), .vga_g(vg[2]), .vga_b(vb[2]),
        .vga_hs(hs[2]), .vga_vs(vs[2]), .vga_de(de[2]), .frame_start(fs[2]));

    out_t       q0 [$];
    out_t       q1 [$];
    out_t       q2 [$];
    int         mh [NI];
    int         mv [NI];
    int         ma [NI];
    logic [7:0] hd [NI][4];
    logic       cmode [NI];
    logic [7:0] cval  [NI];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic pde0 = 1'b0, phs0 = 1'b1;
    int de_rise0 = -1, hs_fall0 = -1, hs_rise0 = -1, hs_fall1 = -1;
    int fs_n1 = 0, fs1_a = -1, fs1_b = -1, fs3_a = -1, de_cnt1 = 0, vs_cnt1 = 0;

    function automatic logic [23:0] ref_rgb(input logic [7:0] d);
        int r3, g3, b2, r, g, b;
        r3 = int'(d) / 32;
        g3 = (int'(d) / 4) % 8;
        b2 = int'(d) % 4;
        r  = r3 * 32 + r3 * 4 + r3 / 2;
        g  = g3 * 32 + g3 * 4 + g3 / 2;
        b  = b2 * 85;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic q_reset(input int i);
        case (i)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
        for (int k = 0; k <= P_LAT[i]; k++) begin
            case (i)
                0: q0.push_back(BLANK);
                1: q1.push_back(BLANK);
                default: q2.push_back(BLANK);
            endcase
        end
    endtask

    task automatic q_push_pop(input int i, input out_t e, output out_t o);
        case (i)
            0: begin q0.push_back(e); o = q0.pop_front(); end
            1: begin q1.push_back(e); o = q1.pop_front(); end
            default: begin q2.push_back(e); o = q2.pop_front(); end
        endcase
    endtask

    // One clock: advance the raster model, serve the RAM, push expectations, compare outputs.
    task automatic tick();
        logic rs, de_m;
        int   ht, vt;
        out_t e, x, o;
        rs = reset_n;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            ht = P_HA[i] + P_HFP[i] + P_HS[i] + P_HBP[i];
            vt = P_VA[i] + P_VFP[i] + P_VS[i] + P_VBP[i];
            if (!rs) begin
                mh[i] = 0; mv[i] = 0; ma[i] = 0;
                q_reset(i);
            end else begin
                de_m = (mh[i] < P_HA[i]) && (mv[i] < P_VA[i]);
                if (mh[i] == ht - 1 && mv[i] == vt - 1) ma[i] = 0;
                else if (de_m) ma[i] = ma[i] + 1;
                if (mh[i] == ht - 1) begin
                    mh[i] = 0;
                    mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
                end else begin
                    mh[i] = mh[i] + 1;
                end
            end
            for (int k = 3; k > 0; k--) hd[i][k] = hd[i][k-1];
            hd[i][0] = cmode[i] ? cval[i] : addr[i][7:0];
            rd[i] = hd[i][P_LAT[i]];
            check($sformatf("addr%0d", i), 32'(addr[i]), 32'(ma[i]));
            if (mh[i] == P_HA[i] - 1 && mv[i] == P_VA[i] - 1)
                check($sformatf("last_addr%0d", i), 32'(addr[i]), 32'(P_HA[i] * P_VA[i] - 1));
            de_m  = (mh[i] < P_HA[i]) && (mv[i] < P_VA[i]);
            e.de  = de_m;
            e.hs  = !(mh[i] >= P_HA[i] + P_HFP[i] && mh[i] < P_HA[i] + P_HFP[i] + P_HS[i]);
            e.vs  = !(mv[i] >= P_VA[i] + P_VFP[i] && mv[i] < P_VA[i] + P_VFP[i] + P_VS[i]);
            e.fs  = (mh[i] == 0) && (mv[i] == 0);
            e.rgb = de_m ? ref_rgb(cmode[i] ? cval[i] : 8'(ma[i] % 256)) : 24'h0;
            q_push_pop(i, e, x);
            o = {de[i], hs[i], vs[i], fs[i], vr[i], vg[i], vb[i]};
            check($sformatf("out%0d", i), 32'(o), 32'(x));
        end
        if (cyc < 2000) begin
            if (de[0] && !pde0 && de_rise0 < 0) de_rise0 = cyc;
            if (!hs[0] && phs0) begin
                if (hs_fall0 < 0) hs_fall0 = cyc;
                else if (hs_fall1 < 0) hs_fall1 = cyc;
            end
            if (hs[0] && !phs0 && hs_fall0 >= 0 && hs_rise0 < 0) hs_rise0 = cyc;
        end
        pde0 = de[0];
        phs0 = hs[0];
        if (cyc < 2 * S_FRAME) begin
            if (fs[1]) begin
                fs_n1++;
                if (fs_n1 == 1) fs1_a = cyc;
                else if (fs_n1 == 2) fs1_b = cyc;
            end
            if (fs_n1 == 1) begin
                if (de[1]) de_cnt1++;
                if (!vs[1]) vs_cnt1++;
            end
            if (fs[2] && fs3_a < 0) fs3_a = cyc;
        end
    endtask

    task automatic run_until_h(input int i, input int h, input int maxc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (mh[i] != h && n < maxc);
        check("wait_h", 32'(mh[i]), 32'(h));
    endtask

    logic [7:0]  cv   [4] = '{8'hE0, 8'h1C, 8'h03, 8'h92};
    logic [23:0] cexp [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h9292AA};

    initial begin
        int n;
        reset_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            cmode[i] = 1'b1;
            cval[i]  = 8'hFF;
            rd[i]    = 8'hFF;
            mh[i] = 0; mv[i] = 0; ma[i] = 0;
            for (int k = 0; k < 4; k++) hd[i][k] = 8'hFF;
        end

        // Reset held for five clocks with all-ones read data
        repeat (4) tick();
        for (int i = 0; i < NI; i++) cmode[i] = 1'b0;
        tick();
        check("reset_out", 32'({de[0], hs[0], vs[0], fs[0], vr[0], vg[0], vb[0]}), 32'h0600_0000);
        check("reset_addr", 32'(addr[0]), 32'h0);
        reset_n = 1'b1;
        cyc = 0;
        tick();
        check("read_clock", 32'(rclk[0]), 32'(clk));

        // Constant-colour lines on the full-size raster
        for (int j = 0; j < 4; j++) begin
            run_until_h(0, 700, 900);
            cmode[0] = 1'b1;
            cval[0]  = cv[j];
            run_until_h(0, 102, 900);
            check($sformatf("colour%0d", j), 32'({vr[0], vg[0], vb[0]}), 32'(cexp[j]));
            run_until_h(0, 702, 900);
            check($sformatf("blank%0d", j), 32'({vr[0], vg[0], vb[0]}), 32'h0);
        end
        run_until_h(0, 700, 900);
        cmode[0] = 1'b0;

        check("de_rise_cycle", 32'(de_rise0), 32'd2);
        check("hs_fall_after_de", 32'(hs_fall0 - de_rise0), 32'd656);
        check("hs_low_width", 32'(hs_rise0 - hs_fall0), 32'd96);
        check("hs_period", 32'(hs_fall1 - hs_fall0), 32'd800);
        check("s1_fs_first", 32'(fs1_a), 32'd2);
        check("s1_fs_count", 32'(fs_n1), 32'd2);
        check("s1_frame_period", 32'(fs1_b - fs1_a), 32'(S_FRAME));
        check("s1_de_per_frame", 32'(de_cnt1), 32'(S_HA * S_VA));
        check("s1_vs_low_per_frame", 32'(vs_cnt1), 32'(S_VS * (S_HA + S_HFP + S_HS + S_HBP)));
        check("s3_fs_first", 32'(fs3_a), 32'd4);

        // Mid-frame reset pulse at h=300
        run_until_h(0, 300, 900);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_out", 32'({de[0], hs[0], vs[0], fs[0], vr[0], vg[0], vb[0]}), 32'h0600_0000);
        check("midrst_addr", 32'(addr[0]), 32'h0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!de[0] && n < 10);
        check("midrst_de_latency", 32'(n), 32'd2);
        check("midrst_pix0", 32'({fs[0], de[0], vr[0], vg[0], vb[0]}), 32'h0300_0000);
        tick();
        check("midrst_pix1", 32'({fs[0], de[0], vr[0], vg[0], vb[0]}), 32'h0100_0055);

        repeat (1000) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_framebuffer_scanout.md
Name: vga_framebuffer_scanout

Overview:
Read side of the 640x480 8-bit framebuffer. The test pattern generator and application write the buffer; this block reads it.
- Generates VGA 640x480@60 timing from the 25 MHz vga_clock.
- Issues a linear read address per active pixel.
- Expands returned RRRGGGBB bytes to 24-bit RGB.
- Emits HS/VS/DE aligned with the colour data.
- Sits between the dual-port framebuffer read port and the HDMI/VGA transmitter.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
READ_LATENCY, 1, framebuffer read latency in clocks, legal range 1..3

Ports:
vga_clock  in  1  pixel clock, 25 MHz
reset_n  in  1  synchronous, active-low reset
read_clock  out  1  framebuffer read-port clock, equal to vga_clock
read_address  out  19  linear pixel address, v*H_ACTIVE+h
read_data  in  8  pixel byte {R[2:0],G[2:0],B[1:0]}, valid READ_LATENCY clocks after its address
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
vga_hs  out  1  horizontal sync, active low
vga_vs  out  1  vertical sync, active low
vga_de  out  1  data enable, high for visible pixels
frame_start  out  1  one-clock pulse coincident with pixel (0,0) on the outputs

Behaviour:
- Reset: reset_n sampled on the vga_clock rising edge; reset_n is synchronous, active-low, clock is vga_clock.
  - Counters and read_address go to 0.
  - vga_hs=1, vga_vs=1, vga_de=0, rgb=0, frame_start=0.
  - All delay-pipeline stages are cleared to their blank/inactive values.
  - Reset mid-frame abandons the frame. The first post-reset cycle is h=0, v=0. No stale pixel may appear on the outputs.
- Counters:
  - H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
  - h_count runs 0..H_TOTAL-1 and wraps to 0.
  - v_count increments when h_count wraps and itself wraps to 0 after V_TOTAL-1.
- Raw (undelayed) signals:
  - de_raw = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs_raw = 0 for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw = 0 for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491, for the whole line.
- Address generation (incremental; no multiplier):
  - read_address presents the current pixel's address during every de_raw cycle.
  - It increments by 1 after each de_raw cycle and holds during blanking.
  - After pixel (639,479) it holds at 307200.
  - It clears to 0 on the clock where h=H_TOTAL-1 and v=V_TOTAL-1, so it is 0 at pixel (0,0).
  - It never exceeds 307200.
- Alignment:
  - de_raw, hs_raw, vs_raw and first_raw (h==0 && v==0) pass through a shift pipeline of depth READ_LATENCY.
  - The output stage registers them once more, together with colour.
  - Total latency from address issue to outputs = READ_LATENCY+1 clocks for every output.
- Colour expansion, registered. d = read_data.
  - vga_r = {d[7:5], d[7:5], d[7:6]}
  - vga_g = {d[4:2], d[4:2], d[4:3]}
  - vga_b = {d[1:0], d[1:0], d[1:0], d[1:0]}
  - When the delayed DE is 0, all rgb outputs are 0 regardless of read_data.
- frame_start equals the delayed first_raw, so it is high exactly one clock per frame, together with vga_de=1.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 timing constants, plus derived H_TOTAL, V_TOTAL and FB_PIXELS=307200;
  - the address width (19);
  - a function rgb332_expand(byte) returning {r,g,b}.
  - The existing writer also uses this package for its address width.
- One sub-module, vga_timing_generator: h/v counters, de_raw/hs_raw/vs_raw/first_raw and the address counter.
- The top level holds the delay pipeline, colour expansion and output registers.

Test Plan:
- Reset: hold reset_n=0 for 5 clocks with read_data=8'hFF.
  - Required: vga_hs=1, vga_vs=1, vga_de=0, rgb=0, read_address=0, frame_start=0 throughout.
- Timing: run 2 full frames.
  - HS period 800 clocks, low for 96 clocks starting 656 clocks after DE rises.
  - VS low for exactly 1600 clocks per frame.
  - DE high for 307200 clocks per frame.
  - Frame period 420000 clocks.
  - frame_start pulses twice, exactly 420000 apart.
- Address/data path: RAM model with read_data = addr[7:0] and READ_LATENCY=1.
  - Required: each DE-high output pixel k of the frame equals rgb332_expand(k mod 256).
  - Required: read_address = 307199 on the last active pixel and 0 at (0,0) of the next frame.
- Colour expansion: read_data constant at each value in turn.
  - 8'hE0 -> FF/00/00
  - 8'h1C -> 00/FF/00
  - 8'h03 -> 00/00/FF
  - 8'h92 -> 92/92/AA
  - During blanking the outputs are 00/00/00.
- Mid-frame reset: pulse reset_n low for 1 clock at h=300, v=100.
  - Required: next clock outputs are at reset values.
  - Required: the next DE rise carries the pixel for address 0, and frame_start asserts with it.
- Latency variant: READ_LATENCY=3 with the same RAM model.
  - Required: identical pixel/sync correspondence; all outputs shifted by exactly 4 clocks relative to address issue.
